// File: rtl/ahb_lite_pkg.sv
// Shared encodings for the AHB-Lite fabric: transfer types, responses and
// the built-in default-slave state type.
package ahb_lite_pkg;

    typedef enum logic [1:0] {
        TRANS_IDLE   = 2'b00,
        TRANS_BUSY   = 2'b01,
        TRANS_NONSEQ = 2'b10,
        TRANS_SEQ    = 2'b11
    } htrans_t;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    typedef enum logic [1:0] {
        DS_IDLE = 2'b00,
        DS_ERR1 = 2'b01,
        DS_ERR2 = 2'b10
    } ds_state_t;

endpackage

// File: rtl/ahb_fabric_watchdog.sv
// Counts slave wait states in the data phase and forces a two-cycle ERROR
// response when a slave stalls for TIMEOUT_CYCLES cycles.
module ahb_fabric_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       active,
    input  logic       slave_ready,
    input  logic       hready,
    input  logic [3:0] slave_idx,
    output logic       force_err,
    output logic       force_ready,
    output logic       irq,
    output logic [3:0] timeout_slave
);

    localparam int              CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam bit              ENABLED = (TIMEOUT_CYCLES > 0);

    logic [CNT_W-1:0] wait_cnt;
    logic             err2;
    logic             stalled;

    assign stalled = ENABLED && active && !slave_ready;

    // A slave raising HREADYOUT in the would-be firing cycle clears stalled and wins.
    assign irq         = stalled && (wait_cnt == LIMIT) && !err2;
    assign force_err   = irq || err2;
    assign force_ready = err2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt      <= '0;
            err2          <= 1'b0;
            timeout_slave <= 4'd0;
        end else begin
            err2 <= irq;
            if (hready)
                wait_cnt <= '0;
            else if (stalled && (wait_cnt != LIMIT))
                wait_cnt <= wait_cnt + CNT_W'(1);
            if (irq)
                timeout_slave <= slave_idx;
        end
    end

endmodule

// File: rtl/ahb_lite_fabric.sv
// Single-master AHB-Lite fabric: address decode, data-phase response mux,
// built-in default slave for unmapped regions and a stall watchdog.
module ahb_lite_fabric
    import ahb_lite_pkg::*;
#(
    parameter int NO_OF_SLAVES   = 4,
    parameter int P_BITS         = 4,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                               HCLK,
    input  logic                               HRESETn,
    input  logic [ADDR_WIDTH-1:0]              HADDR,
    input  logic [1:0]                         HTRANS,
    output logic [NO_OF_SLAVES-1:0]            HSEL_S,
    input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
    input  logic [2*NO_OF_SLAVES-1:0]          HRESP_S,
    input  logic [NO_OF_SLAVES-1:0]            HREADYOUT_S,
    output logic [DATA_WIDTH-1:0]              HRDATA,
    output logic [1:0]                         HRESP,
    output logic                               HREADY,
    output logic                               timeout_irq,
    output logic [3:0]                         timeout_slave,
    output logic [15:0]                        err_count
);

    localparam logic [P_BITS-1:0] N_MAPPED       = P_BITS'(NO_OF_SLAVES);
    localparam logic [P_BITS-1:0] DEFAULT_REGION = '1;

    logic [P_BITS-1:0]     region;
    logic                  region_mapped;
    logic                  addr_active;
    logic                  unmapped_req;
    logic [P_BITS-1:0]     dsel;
    logic                  dact;
    logic                  dsel_ext;
    ds_state_t             ds_state;
    logic                  ds_ready;
    logic                  ds_err;
    logic [DATA_WIDTH-1:0] slv_rdata;
    logic [1:0]            slv_resp;
    logic                  slv_ready;
    logic                  wd_force;
    logic                  wd_ready;
    logic                  unused_addr_bits;

    assign region           = HADDR[ADDR_WIDTH-1 -: P_BITS];
    assign unused_addr_bits = ^HADDR[ADDR_WIDTH-P_BITS-1:0];
    assign region_mapped    = (region < N_MAPPED);
    assign addr_active      = (HTRANS == TRANS_NONSEQ) || (HTRANS == TRANS_SEQ);
    assign unmapped_req     = HREADY && !region_mapped && addr_active;
    assign dsel_ext         = (dsel < N_MAPPED);

    always_comb begin
        HSEL_S = '0;
        for (int i = 0; i < NO_OF_SLAVES; i++)
            if (region == P_BITS'(i))
                HSEL_S[i] = 1'b1;
    end

    always_comb begin
        slv_rdata = '0;
        slv_resp  = HRESP_OKAY;
        slv_ready = 1'b1;
        for (int i = 0; i < NO_OF_SLAVES; i++)
            if (dsel == P_BITS'(i)) begin
                slv_rdata = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
                slv_resp  = HRESP_S[2*i +: 2];
                slv_ready = HREADYOUT_S[i];
            end
    end

    always_comb begin
        HRDATA = '0;
        HRESP  = HRESP_OKAY;
        HREADY = 1'b1;
        if (wd_force) begin
            HRESP  = HRESP_ERROR;
            HREADY = wd_ready;
        end else if (dsel_ext) begin
            HRDATA = slv_rdata;
            HRESP  = slv_resp;
            HREADY = slv_ready;
        end else begin
            HRESP  = ds_err ? HRESP_ERROR : HRESP_OKAY;
            HREADY = ds_ready;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            dsel <= DEFAULT_REGION;
            dact <= 1'b0;
        end else if (HREADY) begin
            dsel <= region;
            dact <= HTRANS[1];
        end
    end

    // Default slave answers unmapped active transfers with a two-cycle ERROR.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            ds_state <= DS_IDLE;
            ds_ready <= 1'b1;
            ds_err   <= 1'b0;
        end else begin
            case (ds_state)
                DS_IDLE: if (unmapped_req) begin
                    ds_state <= DS_ERR1;
                    ds_ready <= 1'b0;
                    ds_err   <= 1'b1;
                end
                DS_ERR1: begin
                    ds_state <= DS_ERR2;
                    ds_ready <= 1'b1;
                    ds_err   <= 1'b1;
                end
                DS_ERR2: if (unmapped_req) begin
                    ds_state <= DS_ERR1;
                    ds_ready <= 1'b0;
                    ds_err   <= 1'b1;
                end else begin
                    ds_state <= DS_IDLE;
                    ds_ready <= 1'b1;
                    ds_err   <= 1'b0;
                end
                default: begin
                    ds_state <= DS_IDLE;
                    ds_ready <= 1'b1;
                    ds_err   <= 1'b0;
                end
            endcase
        end
    end

    ahb_fabric_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk          (HCLK),
        .rst_n        (HRESETn),
        .active       (dsel_ext && dact),
        .slave_ready  (slv_ready),
        .hready       (HREADY),
        .slave_idx    (4'(dsel)),
        .force_err    (wd_force),
        .force_ready  (wd_ready),
        .irq          (timeout_irq),
        .timeout_slave(timeout_slave)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            err_count <= 16'd0;
        else if (HREADY && (HRESP == HRESP_ERROR) && (err_count != 16'hFFFF))
            err_count <= err_count + 16'd1;
    end

endmodule

// File: tb/tb_ahb_lite_fabric.sv
// Directed bench for ahb_lite_fabric: decode, default slave, watchdog,
// slave error pass-through, back-to-back transfers and reset during timeout.
module tb_ahb_lite_fabric;

    logic         HCLK;
    logic         HRESETn;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic [3:0]   HSEL_S;
    logic [127:0] hrdata_s;
    logic [7:0]   hresp_s;
    logic [3:0]   hreadyout_s;
    logic [31:0]  HRDATA;
    logic [1:0]   HRESP;
    logic         HREADY;
    logic         timeout_irq;
    logic [3:0]   timeout_slave;
    logic [15:0]  err_count;

    int tests = 0;
    int fails = 0;

    ahb_lite_fabric #(
        .NO_OF_SLAVES  (4),
        .P_BITS        (4),
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .HCLK         (HCLK),
        .HRESETn      (HRESETn),
        .HADDR        (HADDR),
        .HTRANS       (HTRANS),
        .HSEL_S       (HSEL_S),
        .HRDATA_S     (hrdata_s),
        .HRESP_S      (hresp_s),
        .HREADYOUT_S  (hreadyout_s),
        .HRDATA       (HRDATA),
        .HRESP        (HRESP),
        .HREADY       (HREADY),
        .timeout_irq  (timeout_irq),
        .timeout_slave(timeout_slave),
        .err_count    (err_count)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running, need finished");
        $fatal(1);
    end

    task automatic next_cycle;
        @(posedge HCLK);
        #1;
    endtask

    task automatic test_reset;
        HRESETn     = 1'b0;
        HADDR       = 32'h0;
        HTRANS      = 2'b00;
        hreadyout_s = 4'hF;
        hresp_s     = 8'h00;
        for (int i = 0; i < 4; i++) hrdata_s[i*32 +: 32] = 32'hA5A5_0000 + i;
        #12;
        tests++; if (HREADY !== 1'b1) begin fails++; $display("FAIL reset_hready: got %b need 1", HREADY); end
        tests++; if (HRESP !== 2'b00) begin fails++; $display("FAIL reset_hresp: got %b need 00", HRESP); end
        tests++; if (HRDATA !== 32'h0) begin fails++; $display("FAIL reset_hrdata: got %h need 0", HRDATA); end
        tests++; if (timeout_irq !== 1'b0 || timeout_slave !== 4'd0) begin fails++; $display("FAIL reset_wd: got irq=%b slave=%0d need 0/0", timeout_irq, timeout_slave); end
        tests++; if (err_count !== 16'd0) begin fails++; $display("FAIL reset_errcnt: got %0d need 0", err_count); end
        next_cycle;
        HRESETn = 1'b1;
    endtask

    task automatic test_decode;
        next_cycle;
        HADDR = 32'h1000_0040; HTRANS = 2'b10;
        @(negedge HCLK);
        tests++; if (HSEL_S !== 4'b0010) begin fails++; $display("FAIL decode_hsel1: got %b need 0010", HSEL_S); end
        next_cycle;
        HADDR = 32'h3000_0000; HTRANS = 2'b00;
        @(negedge HCLK);
        tests++; if (HRDATA !== 32'hA5A5_0001 || HRESP !== 2'b00 || HREADY !== 1'b1) begin fails++; $display("FAIL decode_read1: got %h/%b/%b need a5a50001/00/1", HRDATA, HRESP, HREADY); end
        tests++; if (HSEL_S !== 4'b1000) begin fails++; $display("FAIL decode_hsel3_idle: got %b need 1000", HSEL_S); end
        next_cycle;
        HADDR = 32'h5000_0000;
        @(negedge HCLK);
        tests++; if (HSEL_S !== 4'b0000) begin fails++; $display("FAIL decode_hsel_unmapped: got %b need 0000", HSEL_S); end
    endtask

    task automatic test_default_slave;
        next_cycle;
        HADDR = 32'hF000_0000; HTRANS = 2'b10;
        @(negedge HCLK);
        tests++; if (HSEL_S !== 4'b0000 || HREADY !== 1'b1) begin fails++; $display("FAIL dflt_addr: got hsel=%b hready=%b need 0000/1", HSEL_S, HREADY); end
        next_cycle;
        HTRANS = 2'b00;
        @(negedge HCLK);
        tests++; if (HREADY !== 1'b0 || HRESP !== 2'b01 || HRDATA !== 32'h0) begin fails++; $display("FAIL dflt_err1: got %b/%b/%h need 0/01/0", HREADY, HRESP, HRDATA); end
        next_cycle;
        @(negedge HCLK);
        tests++; if (HREADY !== 1'b1 || HRESP !== 2'b01 || err_count !== 16'd0) begin fails++; $display("FAIL dflt_err2: got %b/%b cnt=%0d need 1/01 cnt=0", HREADY, HRESP, err_count); end
        next_cycle;
        @(negedge HCLK);
        tests++; if (HREADY !== 1'b1 || HRESP !== 2'b00 || err_count !== 16'd1) begin fails++; $display("FAIL dflt_idle_after: got %b/%b cnt=%0d need 1/00 cnt=1", HREADY, HRESP, err_count); end
        next_cycle;
        @(negedge HCLK);
        tests++; if (HREADY !== 1'b1 || HRESP !== 2'b00 || err_count !== 16'd1) begin fails++; $display("FAIL dflt_idle_xfer: got %b/%b cnt=%0d need 1/00 cnt=1", HREADY, HRESP, err_count); end
    endtask

    task automatic test_slave_error;
        next_cycle;
        HADDR = 32'h1000_0000; HTRANS = 2'b10;
        next_cycle;
        HTRANS = 2'b00; HADDR = 32'h0; hreadyout_s[1] = 1'b0; hresp_s[3:2] = 2'b01;
        @(negedge HCLK);
        tests++; if (HREADY !== 1'b0 || HRESP !== 2'b01) begin fails++; $display("FAIL slverr_c1: got %b/%b need 0/01", HREADY, HRESP); end
        next_cycle;
        hreadyout_s[1] = 1'b1;
        @(negedge HCLK);
        tests++; if (HREADY !== 1'b1 || HRESP !== 2'b01) begin fails++; $display("FAIL slverr_c2: got %b/%b need 1/01", HREADY, HRESP); end
        next_cycle;
        hresp_s[3:2] = 2'b00;
        @(negedge HCLK);
        tests++; if (err_count !== 16'd2 || HRESP !== 2'b00) begin fails++; $display("FAIL slverr_count: got cnt=%0d resp=%b need 2/00", err_count, HRESP); end
    endtask

    task automatic test_timeout;
        int irq_pulses;
        int early_bad;
        irq_pulses = 0;
        early_bad  = 0;
        next_cycle;
        HADDR = 32'h2000_0000; HTRANS = 2'b10; hreadyout_s[2] = 1'b0;
        next_cycle;
        HADDR = 32'h0; HTRANS = 2'b00;
        for (int i = 0; i < 16; i++) begin
            @(negedge HCLK);
            if (HREADY !== 1'b0 || timeout_irq !== 1'b0) early_bad++;
            irq_pulses += int'(timeout_irq);
            next_cycle;
        end
        tests++; if (early_bad != 0) begin fails++; $display("FAIL to_waits: got %0d bad wait cycles need 0", early_bad); end
        @(negedge HCLK);
        irq_pulses += int'(timeout_irq);
        tests++; if (HREADY !== 1'b0 || HRESP !== 2'b01 || timeout_irq !== 1'b1) begin fails++; $display("FAIL to_force1: got %b/%b irq=%b need 0/01 irq=1", HREADY, HRESP, timeout_irq); end
        next_cycle;
        @(negedge HCLK);
        irq_pulses += int'(timeout_irq);
        tests++; if (HREADY !== 1'b1 || HRESP !== 2'b01 || timeout_slave !== 4'd2) begin fails++; $display("FAIL to_force2: got %b/%b slave=%0d need 1/01 slave=2", HREADY, HRESP, timeout_slave); end
        tests++; if (irq_pulses != 1) begin fails++; $display("FAIL to_irq_pulses: got %0d need 1", irq_pulses); end
        next_cycle;
        @(negedge HCLK);
        tests++; if (err_count !== 16'd3 || HREADY !== 1'b1) begin fails++; $display("FAIL to_count: got cnt=%0d hready=%b need 3/1", err_count, HREADY); end
        hreadyout_s[2] = 1'b1;
    endtask

    task automatic test_slave_wins;
        next_cycle;
        HADDR = 32'h2000_0000; HTRANS = 2'b10; hreadyout_s[2] = 1'b0;
        next_cycle;
        HADDR = 32'h0; HTRANS = 2'b00;
        repeat (16) next_cycle;
        hreadyout_s[2] = 1'b1;
        @(negedge HCLK);
        tests++; if (HREADY !== 1'b1 || HRESP !== 2'b00 || timeout_irq !== 1'b0 || HRDATA !== 32'hA5A5_0002) begin fails++; $display("FAIL win_slave: got %b/%b irq=%b data=%h need 1/00 irq=0 a5a50002", HREADY, HRESP, timeout_irq, HRDATA); end
        next_cycle;
        @(negedge HCLK);
        tests++; if (err_count !== 16'd3) begin fails++; $display("FAIL win_count: got %0d need 3", err_count); end
    endtask

    task automatic test_back_to_back;
        int bad_waits;
        bad_waits = 0;
        next_cycle;
        HADDR = 32'h0000_0000; HTRANS = 2'b10; hreadyout_s[0] = 1'b0;
        next_cycle;
        HADDR = 32'h3000_0000; HTRANS = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge HCLK);
            if (HREADY !== 1'b0 || HRDATA !== 32'hA5A5_0000 || HSEL_S !== 4'b1000) bad_waits++;
            next_cycle;
        end
        tests++; if (bad_waits != 0) begin fails++; $display("FAIL b2b_hold: got %0d bad wait cycles need 0", bad_waits); end
        hreadyout_s[0] = 1'b1;
        @(negedge HCLK);
        tests++; if (HREADY !== 1'b1 || HRDATA !== 32'hA5A5_0000) begin fails++; $display("FAIL b2b_first: got %b/%h need 1/a5a50000", HREADY, HRDATA); end
        next_cycle;
        HTRANS = 2'b00;
        @(negedge HCLK);
        tests++; if (HREADY !== 1'b1 || HRESP !== 2'b00 || HRDATA !== 32'hA5A5_0003) begin fails++; $display("FAIL b2b_second: got %b/%b/%h need 1/00/a5a50003", HREADY, HRESP, HRDATA); end
    endtask

    task automatic test_reset_in_fire;
        next_cycle;
        HADDR = 32'h2000_0000; HTRANS = 2'b10; hreadyout_s[2] = 1'b0;
        next_cycle;
        HADDR = 32'h0; HTRANS = 2'b00;
        repeat (16) next_cycle;
        @(negedge HCLK);
        tests++; if (timeout_irq !== 1'b1 || HREADY !== 1'b0) begin fails++; $display("FAIL rst_pre_fire: got irq=%b hready=%b need 1/0", timeout_irq, HREADY); end
        #1;
        HRESETn = 1'b0;
        #1;
        tests++; if (HREADY !== 1'b1 || HRESP !== 2'b00) begin fails++; $display("FAIL rst_fire_bus: got %b/%b need 1/00", HREADY, HRESP); end
        tests++; if (err_count !== 16'd0 || timeout_irq !== 1'b0 || timeout_slave !== 4'd0) begin fails++; $display("FAIL rst_fire_state: got cnt=%0d irq=%b slave=%0d need 0/0/0", err_count, timeout_irq, timeout_slave); end
        hreadyout_s[2] = 1'b1;
        next_cycle;
        HRESETn = 1'b1;
        next_cycle;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_default_slave();
        test_slave_error();
        test_timeout();
        test_slave_wins();
        test_back_to_back();
        test_reset_in_fire();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ahb_lite_fabric.md
AHB_LITE_FABRIC -- requirements
Module: ahb_lite_fabric

Interface
REQ-001 SHALL have parameter NO_OF_SLAVES, 4, number of external slave ports (1..15); regions >= NO_OF_SLAVES map to built-in default slave.
REQ-002 SHALL have parameter P_BITS, 4, number of top HADDR bits forming region index; 2**P_BITS > NO_OF_SLAVES required.
REQ-003 SHALL have parameter ADDR_WIDTH, 32, address width.
REQ-004 SHALL have parameter DATA_WIDTH, 32, data width.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, 16, max slave wait states before forced ERROR; 0 disables watchdog.
REQ-006 SHALL have port HCLK  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port HRESETn  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port HADDR  input  ADDR_WIDTH  master address-phase address.
REQ-009 SHALL have port HTRANS  input  2  transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11).
REQ-010 SHALL have port HSEL_S  output  NO_OF_SLAVES  one-hot slave select.
REQ-011 SHALL have port HRDATA_S  input  NO_OF_SLAVES*DATA_WIDTH  packed slave read data, slave i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-012 SHALL have port HRESP_S  input  2*NO_OF_SLAVES  packed slave responses, slave i at [2*i +: 2].
REQ-013 SHALL have port HREADYOUT_S  input  NO_OF_SLAVES  per-slave ready.
REQ-014 SHALL have port HRDATA  output  DATA_WIDTH  read data to master.
REQ-015 SHALL have port HRESP  output  2  response to master (OKAY 00, ERROR 01).
REQ-016 SHALL have port HREADY  output  1  transfer done; also drives every slave's HREADYin.
REQ-017 SHALL have port timeout_irq  output  1  one-cycle pulse when watchdog fires.
REQ-018 SHALL have port timeout_slave  output  4  index of last timed-out slave, held until next fire.
REQ-019 SHALL have port err_count  output  16  saturating count of ERROR completions to master.

Function
REQ-020 Region = HADDR[ADDR_WIDTH-1 -: P_BITS]; HSEL_S[region]=1 combinationally when region < NO_OF_SLAVES, else all zero (default slave selected); independent of HTRANS.
REQ-021 Data-phase register {dsel, dact} SHALL load {region, HTRANS[1]} on clock edge when HREADY=1 and hold when HREADY=0.
REQ-022 dsel external: HRDATA/HRESP/HREADY SHALL equal slave dsel's signals, unless watchdog override active.
REQ-023 dsel default: HRDATA SHALL be 0; HRESP/HREADY from default-slave FSM.
REQ-024 Default FSM states DS_IDLE, DS_ERR1, DS_ERR2; DS_IDLE -> DS_ERR1 when HREADY=1, region unmapped, HTRANS NONSEQ/SEQ; DS_ERR1 -> DS_ERR2 unconditionally; DS_ERR2 -> DS_ERR1 on another sampled unmapped active transfer, else DS_IDLE.
REQ-025 Default outputs: DS_IDLE HREADY=1 HRESP=OKAY; DS_ERR1 HREADY=0 HRESP=ERROR; DS_ERR2 HREADY=1 HRESP=ERROR.
REQ-026 Watchdog counter SHALL increment each cycle with dsel external, dact=1, HREADYOUT_S[dsel]=0; clear when HREADY=1.
REQ-027 After TIMEOUT_CYCLES counted wait states with slave still low, fabric SHALL force cycle 1 (HREADY=0, HRESP=ERROR) then cycle 2 (HREADY=1, HRESP=ERROR), ignoring slave; timeout_irq=1 in cycle 1; timeout_slave loads dsel.
REQ-028 Slave HREADYOUT rising on the firing cycle SHALL win: slave response passed, no timeout.
REQ-029 Watchdog SHALL be inactive when dact=0 or TIMEOUT_CYCLES=0.
REQ-030 err_count SHALL increment once per cycle with HREADY=1 and HRESP=ERROR; saturate at 16'hFFFF.
REQ-031 Slave-generated ERROR SHALL pass through unmodified.

Reset
REQ-032 HRESETn low SHALL immediately force: dsel=default region, dact=0, FSM DS_IDLE, watchdog 0, HREADY=1, HRESP=OKAY, HRDATA=0, timeout_irq=0, timeout_slave=0, err_count=0; in-flight transfer abandoned.

Structure
REQ-033 Shared package ahb_lite_pkg SHALL hold HTRANS and HRESP encodings and default-FSM state type.
REQ-034 Watchdog SHALL be sub-module ahb_fabric_watchdog; decode, mux, default FSM inline.

Verification
REQ-035 NONSEQ read 0x1000_0040, slave1 HRDATA=0xA5A5_0001 zero-wait -> HSEL_S=0010 in address phase; next cycle HRDATA=0xA5A5_0001, HRESP=00, HREADY=1.
REQ-036 NONSEQ to 0xF000_0000 -> HREADY=0/HRESP=01 then HREADY=1/HRESP=01; err_count 0->1; IDLE to same address -> HREADY=1, HRESP=00, no count.
REQ-037 TIMEOUT_CYCLES=16, slave2 holds HREADYOUT low 20 cycles -> 16 wait cycles, two forced-ERROR cycles, timeout_irq single pulse, timeout_slave=2, err_count +1.
REQ-038 Back-to-back NONSEQ region 0 (3 wait states) then region 3 -> dsel held during waits, slave3 response only after slave0 completes.
REQ-039 HRESETn asserted during forced-ERROR cycle 1 -> same cycle HREADY=1, HRESP=00, err_count=0, timeout_irq=0.
